// File: rtl/multiplier_word.sv
// multiplier_word: sequential 32x32 -> 64-bit unsigned shift-add multiplier.
// One iteration per cycle through a combinational 32-bit ripple adder.
// Accepted start -> 32 RUN cycles -> one DONE cycle with the product valid.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   start    request, sampled only when not busy (IDLE or DONE)
//   a, b     multiplicand / multiplier, captured on an accepted start
//   busy     high while RUN
//   done     one-cycle pulse, product valid
//   product  {acc_hi, acc_lo}; held until the next accepted start
//
// Optional feature: define MULTIPLIER_ZERO_BYPASS_EN to let a start with a zero
// operand jump straight to DONE with product 0 (done at k+1, busy never set).

// 32-bit ripple-carry adder used as the multiplier's per-cycle datapath.
module adder_word (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_carry_in,
    output logic [31:0] o_sum,
    output logic        o_carry_out
);
    localparam int unsigned W = 32;

    // Carry ripples LSB to MSB through a loop-local variable.
    always_comb begin
        logic c;
        c     = i_carry_in;
        o_sum = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ c;
            c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
        end
        o_carry_out = c;
    end
endmodule

module multiplier_word (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    localparam int unsigned W     = 32;
    localparam int unsigned CW    = 6;
    localparam int unsigned LAST  = 31;

    // One-hot-ish encoding: busy/done are each a single state flop bit.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           w_accept;
    logic           w_zero_op;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_acc_hi;
    logic [W-1:0]   r_acc_lo;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   w_addend;
    logic [W-1:0]   w_sum;
    logic           w_carry;

    // Partial product for this iteration selected by the current multiplier LSB.
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    adder_word u_adder (
        .i_a         (r_acc_hi),
        .i_b         (w_addend),
        .i_carry_in  (1'b0),
        .o_sum       (w_sum),
        .o_carry_out (w_carry)
    );

    // Next-state and accept decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_zero_op    = 1'b0;
`ifdef MULTIPLIER_ZERO_BYPASS_EN
        w_zero_op    = (a == '0) || (b == '0);
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_zero_op ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_zero_op ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_count == CW'(LAST)) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture and shift-add accumulator; carry_out becomes the new acc_hi MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_mcand  <= a;
            r_acc_hi <= '0;
            r_acc_lo <= w_zero_op ? '0 : b;
            r_count  <= '0;
        end else if (r_state == S_RUN) begin
            {r_acc_hi, r_acc_lo} <= {w_carry, w_sum, r_acc_lo[W-1:1]};
            r_count              <= r_count + CW'(1);
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = {r_acc_hi, r_acc_lo};

endmodule

// File: tb/tb_multiplier_word.sv
// Directed testbench for multiplier_word; expected values are hand-computed.
module tb_multiplier_word;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MULTIPLIER_ZERO_BYPASS_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 33;
    localparam int ZERO_BUSY = 32;
`endif

    multiplier_word dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; drive and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle k+1; returns cycles to done (k+1 => 1) and busy cycles seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    // Full operation: accept, wait for done, check result and pulse width.
    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [63:0] exp_p, input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bcnt);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_product"}, product, exp_p);
        tick();
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_product_held"}, product, exp_p);
    endtask

    initial begin
        int lat;
        int bcnt;
        int pulses;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        reset = 1'b0;
        tick();

        // Reset mid-RUN aborts with no done pulse.
        a = 32'd5; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        // Reset and start together: start dropped.
        reset = 1'b1; start = 1'b1; a = 32'd3; b = 32'd3;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy0", 64'(busy), 64'd0);
        tick();
        check("rst_start_busy1", 64'(busy), 64'd0);
        check("rst_start_product", product, 64'd0);

        run_op("basic", 32'd3, 32'd5, 64'd15, 33, 32);
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 32);
        run_op("one_x_max", 32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 33, 32);
        run_op("max_x_two", 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 33, 32);
        run_op("msb_x_two", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 33, 32);
        run_op("zero_a", 32'd0, 32'h1234, 64'd0, ZERO_LAT, ZERO_BUSY);
        run_op("zero_b", 32'h1234, 32'd0, 64'd0, ZERO_LAT, ZERO_BUSY);

        // Start during RUN ignored; start in DONE accepted back-to-back.
        a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bcnt);
        check("ignore_latency", 64'(lat + 5), 64'd33);
        check("ignore_product", product, 64'd6);
        a = 32'd4; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_done_dropped", 64'(done), 64'd0);
        wait_done(lat, bcnt);
        check("b2b_latency", 64'(lat), 64'd33);
        check("b2b_busy_cycles", 64'(bcnt), 64'd32);
        check("b2b_product", product, 64'd16);
        tick();
        check("b2b_idle", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
